uart_frame_link: RTL and testbench
==================================

// Module: uart_frame_link
// PURPOSE
//  Framing layer on the user side of uart_ctl. Sends a fixed-length payload as
//  the frame SYNC, payload bytes (MSB first), CSUM through the uart_ctl TX handshake.
//  Parses received bytes from uart_ctl into the same frames.
//  Used for the two-board game-state link; one instance per board.
// PARAMETERS
//  N_BYTES        4       payload bytes per frame (1..8)
//  SYNC           8'hA5   frame start byte
//  TIMEOUT_CYCLES 312500  RX inter-byte timeout in clk cycles (3 chars @9600 baud, 100 MHz)
// PORTS
//  clk           in   1          system clock, 100 MHz
//  reset         in   1          asynchronous reset, active-low
//  tx_payload    in   8*N_BYTES  payload to send; byte0 = bits [8*N_BYTES-1 -: 8]
//  tx_send       in   1          request to send; accepted only when tx_busy=0
//  tx_busy       out  1          high from accept until the last byte is handed off
//  rx_payload    out  8*N_BYTES  last frame received with a good checksum
//  rx_valid      out  1          1-cycle pulse when rx_payload is updated
//  rx_err        out  1          1-cycle pulse on bad checksum (or timeout, if enabled)
//  uart_tx_data  out  8          to uart_ctl TX_data
//  uart_start_tx out  1          to uart_ctl start_tx
//  uart_tx_ready in   1          from uart_ctl tx_ready
//  uart_rx_done  in   1          from uart_ctl RX_done; 1-cycle strobe per byte
//  uart_rx_data  in   8          from uart_ctl RX_data; valid while uart_rx_done=1
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, rx_payload=0, both FSMs idle.
//  CSUM = 8-bit sum mod 256 of the N_BYTES payload bytes. SYNC is not included.
//  TX FSM: T_IDLE -> T_LOAD -> T_WAITLO -> T_WAITHI -> (T_LOAD | T_IDLE).
//   - T_IDLE: when tx_send=1, latch tx_payload and compute CSUM.
//     Set tx_busy=1 on the next edge. Set byte index=0 (SYNC).
//   - T_LOAD: when uart_tx_ready=1, drive uart_tx_data and pulse uart_start_tx
//     for exactly 1 cycle.
//   - T_WAITLO: wait for uart_tx_ready=0, meaning the byte was accepted.
//   - T_WAITHI: wait for uart_tx_ready=1. Advance the index.
//     Send SYNC, then byte0..byteN-1, then CSUM. After CSUM, return to T_IDLE
//     with tx_busy=0 in the same cycle.
//   - uart_tx_data holds its value from T_LOAD until the next T_LOAD.
//   - tx_send while tx_busy=1 is ignored. A changing tx_payload during a frame
//     has no effect, because the data was latched.
//   - Latency from tx_send to the first uart_start_tx is 2 cycles when
//     uart_tx_ready=1.
//  RX FSM: R_HUNT -> R_DATA -> R_CSUM -> R_HUNT.
//   - R_HUNT: discard every byte except SYNC. On SYNC, clear the running sum
//     and the index.
//   - R_DATA: store each byte into the shadow register, MSB first, and add it
//     to the sum. A SYNC byte here is treated as data (no resync).
//     After N_BYTES bytes, go to R_CSUM.
//   - R_CSUM on the next byte:
//     - match: copy shadow to rx_payload and pulse rx_valid 1 cycle after the
//       strobe.
//     - mismatch: rx_payload is unchanged; pulse rx_err.
//     - Either way, return to R_HUNT.
//   - rx_valid and rx_err are never high in the same cycle.
//  TX and RX FSMs are independent; simultaneous TX and RX activity is allowed.
//  Asserting reset mid-frame aborts both FSMs. A partial TX frame is not
//  completed. The peer resyncs on the next SYNC.
// CONFIGURATION
//  UART_FRAME_TIMEOUT_EN defined:
//   - A counter counts cycles since the last uart_rx_done while in R_DATA or R_CSUM.
//   - Reaching TIMEOUT_CYCLES-1 returns the FSM to R_HUNT and pulses rx_err.
//   - The counter clears on every byte and in R_HUNT.
//  UART_FRAME_TIMEOUT_EN undefined: no counter. A partial frame waits forever.
// TESTING
//  1 tx_send, payload 32'h01020304, uart_ctl model ready -> bytes A5,01,02,03,04,0A;
//    tx_busy=0 after the last handoff.
//  2 RX bytes A5,10,20,30,40,A0 -> rx_valid 1 pulse; rx_payload=32'h10203040; rx_err=0.
//  3 RX bytes A5,10,20,30,40,A1 -> rx_err pulse; rx_payload keeps its previous value.
//  4 RX bytes 00,FF,A5,A5,00,00,00,A5 -> noise discarded; 2nd A5 is data;
//    rx_payload=32'hA5000000.
//  5 tx_send pulsed again mid-frame; reset=0 during byte 2 -> second request
//    ignored; reset gives all outputs 0 with no further start pulses.
//  6 (UART_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100) A5,11 then 100 idle cycles ->
//    rx_err pulse; then A5,01,01,01,01,04 -> rx_valid, rx_payload=32'h01010101.

Source files
------------

// File: rtl/uart_frame_link.sv
// Framing layer over uart_ctl: TX sends SYNC, payload (MSB byte first), CSUM;
// RX hunts for SYNC and checks CSUM. Optional RX timeout: UART_FRAME_TIMEOUT_EN.
module uart_frame_link #(
  parameter int          N_BYTES        = 4,
  parameter logic [7:0]  SYNC           = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 312500
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*N_BYTES-1:0] tx_payload,
  input  logic                 tx_send,
  output logic                 tx_busy,
  output logic [8*N_BYTES-1:0] rx_payload,
  output logic                 rx_valid,
  output logic                 rx_err,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_start_tx,
  input  logic                 uart_tx_ready,
  input  logic                 uart_rx_done,
  input  logic [7:0]           uart_rx_data
);

  localparam int         PW      = 8*N_BYTES;
  localparam logic [3:0] LAST_TX = 4'(N_BYTES+1);
  localparam logic [3:0] LAST_RX = 4'(N_BYTES-1);

  function automatic logic [7:0] csum_of(input logic [PW-1:0] p);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < N_BYTES; i++) s = s + p[8*i +: 8];
    return s;
  endfunction

  // ---------------- TX ----------------
  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WAITLO, T_WAITHI} tx_state_t;
  tx_state_t       t_state, t_next;
  logic [PW-1:0]   t_pay;
  logic [7:0]      t_csum;
  logic [3:0]      t_idx;
  logic [7:0]      t_byte;

  always_ff @(posedge clk or negedge reset)
    if (!reset) t_state <= T_IDLE;
    else        t_state <= t_next;

  always_comb begin
    t_next = t_state;
    case (t_state)
      T_IDLE:   if (tx_send)        t_next = T_LOAD;
      T_LOAD:   if (uart_tx_ready)  t_next = T_WAITLO;
      T_WAITLO: if (!uart_tx_ready) t_next = T_WAITHI;
      T_WAITHI: if (uart_tx_ready)  t_next = (t_idx == LAST_TX) ? T_IDLE : T_LOAD;
      default:                      t_next = T_IDLE;
    endcase
  end

  // index 0 is SYNC, 1..N_BYTES the payload, N_BYTES+1 the checksum
  always_comb begin
    t_byte = SYNC;
    if (t_idx == LAST_TX) t_byte = t_csum;
    for (int i = 0; i < N_BYTES; i++)
      if (t_idx == 4'(i+1)) t_byte = t_pay[PW-8-8*i +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_pay         <= '0;
      t_csum        <= '0;
      t_idx         <= '0;
      tx_busy       <= 1'b0;
      uart_tx_data  <= '0;
      uart_start_tx <= 1'b0;
    end else begin
      uart_start_tx <= 1'b0;
      case (t_state)
        T_IDLE: if (tx_send) begin
          t_pay   <= tx_payload;
          t_csum  <= csum_of(tx_payload);
          t_idx   <= '0;
          tx_busy <= 1'b1;
        end
        T_LOAD: if (uart_tx_ready) begin
          uart_tx_data  <= t_byte;
          uart_start_tx <= 1'b1;
        end
        T_WAITHI: if (uart_tx_ready) begin
          if (t_idx == LAST_TX) tx_busy <= 1'b0;
          else                  t_idx   <= t_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- RX ----------------
  typedef enum logic [1:0] {R_HUNT, R_DATA, R_CSUM} rx_state_t;
  rx_state_t     r_state, r_next;
  logic [PW-1:0] r_shadow;
  logic [7:0]    r_sum;
  logic [3:0]    r_idx;
  logic          r_tmo;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] r_tcnt;

  always_ff @(posedge clk or negedge reset)
    if (!reset)                                         r_tcnt <= '0;
    else if (r_state == R_HUNT || uart_rx_done || r_tmo) r_tcnt <= '0;
    else                                                r_tcnt <= r_tcnt + 1'b1;

  assign r_tmo = (r_state != R_HUNT) && !uart_rx_done &&
                 (r_tcnt == TW'(TIMEOUT_CYCLES-1));
`else
  // timeout disabled: constant-false for any legal TIMEOUT_CYCLES
  assign r_tmo = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= R_HUNT;
    else        r_state <= r_next;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_HUNT: if (uart_rx_done && uart_rx_data == SYNC) r_next = R_DATA;
      R_DATA: begin
        if (r_tmo)                                  r_next = R_HUNT;
        else if (uart_rx_done && r_idx == LAST_RX) r_next = R_CSUM;
      end
      R_CSUM: if (r_tmo || uart_rx_done)           r_next = R_HUNT;
      default:                                      r_next = R_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow   <= '0;
      r_sum      <= '0;
      r_idx      <= '0;
      rx_payload <= '0;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= r_tmo;
      case (r_state)
        R_HUNT: if (uart_rx_done && uart_rx_data == SYNC) begin
          r_sum <= '0;
          r_idx <= '0;
        end
        R_DATA: if (uart_rx_done) begin
          for (int i = 0; i < N_BYTES; i++)
            if (r_idx == 4'(i)) r_shadow[PW-8-8*i +: 8] <= uart_rx_data;
          r_sum <= r_sum + uart_rx_data;
          r_idx <= r_idx + 4'd1;
        end
        R_CSUM: if (uart_rx_done) begin
          if (uart_rx_data == r_sum) begin
            rx_payload <= r_shadow;
            rx_valid   <= 1'b1;
          end else begin
            rx_err     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_link.sv
// Randomized bench for uart_frame_link with a uart_ctl stand-in and a frame-level model.
module tb_uart_frame_link;
  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [8*NB-1:0]   tx_payload = '0;
  logic              tx_send = 1'b0;
  logic              tx_busy;
  logic [8*NB-1:0]   rx_payload;
  logic              rx_valid, rx_err;
  logic [7:0]        uart_tx_data;
  logic              uart_start_tx;
  logic              uart_tx_ready = 1'b1;
  logic              uart_rx_done = 1'b0;
  logic [7:0]        uart_rx_data = '0;

  uart_frame_link #(.N_BYTES(NB), .SYNC(8'hA5), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .tx_payload(tx_payload), .tx_send(tx_send),
    .tx_busy(tx_busy), .rx_payload(rx_payload), .rx_valid(rx_valid), .rx_err(rx_err),
    .uart_tx_data(uart_tx_data), .uart_start_tx(uart_start_tx),
    .uart_tx_ready(uart_tx_ready), .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_valid = 0, n_rxerr = 0, n_both = 0;
  logic [7:0] txq[$];
  int ready_dly = 0;
  logic [31:0] exp_pay = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sum8(input logic [31:0] p);
    return p[31:24] + p[23:16] + p[15:8] + p[7:0];
  endfunction

  // uart_ctl TX stand-in: takes a byte on start, stays busy a random time
  always @(negedge clk) begin
    if (!reset) begin
      uart_tx_ready = 1'b1;
      ready_dly = 0;
    end else if (uart_start_tx) begin
      txq.push_back(uart_tx_data);
      uart_tx_ready = 1'b0;
      ready_dly = $urandom_range(1, 4);
    end else if (!uart_tx_ready) begin
      ready_dly--;
      if (ready_dly <= 0) uart_tx_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rx_valid) n_valid++;
    if (rx_err) n_rxerr++;
    if (rx_valid && rx_err) n_both++;
  end

  task automatic send_rx(input logic [7:0] b, input int gap);
    @(negedge clk);
    uart_rx_done = 1'b1;
    uart_rx_data = b;
    @(negedge clk);
    uart_rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // noise, SYNC, payload, checksum (corrupted when !good)
  task automatic rx_frame(input logic [31:0] p, input bit good, input int noise);
    int v0, e0;
    logic [7:0] cs, nb;
    v0 = n_valid; e0 = n_rxerr;
    for (int i = 0; i < noise; i++) begin
      nb = 8'($urandom_range(0, 255));
      if (nb == 8'hA5) nb = 8'h5A;
      send_rx(nb, $urandom_range(0, 3));
    end
    send_rx(8'hA5, $urandom_range(0, 3));
    for (int i = 0; i < NB; i++) send_rx(p[31-8*i -: 8], $urandom_range(0, 3));
    cs = sum8(p);
    if (!good) cs = cs + 8'($urandom_range(1, 255));
    send_rx(cs, 0);
    chk("rx_valid_pulse", rx_valid, good);
    chk("rx_err_pulse", rx_err, !good);
    if (good) exp_pay = p;
    repeat (2) @(negedge clk);
    chk("rx_valid_cnt", n_valid - v0, good ? 1 : 0);
    chk("rx_err_cnt", n_rxerr - e0, good ? 0 : 1);
    chk("rx_payload", rx_payload, exp_pay);
  endtask

  task automatic tx_frame(input logic [31:0] p);
    logic [7:0] exp_b[NB+2];
    txq.delete();
    exp_b[0] = 8'hA5;
    for (int i = 0; i < NB; i++) exp_b[i+1] = p[31-8*i -: 8];
    exp_b[NB+1] = sum8(p);
    @(negedge clk);
    tx_payload = p;
    tx_send = 1'b1;
    @(negedge clk);
    tx_send = 1'b0;
    chk("tx_busy_set", tx_busy, 1);
    chk("tx_start_early", uart_start_tx, 0);
    @(negedge clk);
    chk("tx_start_lat", uart_start_tx, 1);
    chk("tx_first_byte", uart_tx_data, 8'hA5);
    // second request and new payload while busy must not matter
    tx_payload = ~p;
    tx_send = 1'b1;
    @(negedge clk);
    tx_send = 1'b0;
    for (int c = 0; c < 500 && tx_busy; c++) @(negedge clk);
    chk("tx_busy_clr", tx_busy, 0);
    repeat (10) @(negedge clk);
    chk("tx_nbytes", txq.size(), NB+2);
    for (int i = 0; i < NB+2 && i < txq.size(); i++) chk("tx_byte", txq[i], exp_b[i]);
  endtask

  initial begin
    int n_hold;
    #1;
    chk("rst_busy", tx_busy, 0);
    chk("rst_start", uart_start_tx, 0);
    chk("rst_txdata", uart_tx_data, 0);
    chk("rst_payload", rx_payload, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_err", rx_err, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    tx_frame(32'h01020304);
    rx_frame(32'h10203040, 1'b1, 0);
    rx_frame(32'h10203040, 1'b0, 0);
    // noise, then a SYNC used as payload byte
    begin
      int v0;
      v0 = n_valid;
      send_rx(8'h00, 1); send_rx(8'hFF, 1); send_rx(8'hA5, 0); send_rx(8'hA5, 2);
      send_rx(8'h00, 0); send_rx(8'h00, 1); send_rx(8'h00, 0); send_rx(8'hA5, 0);
      repeat (2) @(negedge clk);
      exp_pay = 32'hA5000000;
      chk("resync_valid", n_valid - v0, 1);
      chk("resync_payload", rx_payload, exp_pay);
    end

    for (int k = 0; k < 6; k++) begin
      tx_frame($urandom);
      rx_frame($urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3));
    end

    fork
      tx_frame($urandom);
      rx_frame($urandom, 1'b1, 2);
    join

    // reset in the middle of a TX frame
    txq.delete();
    @(negedge clk);
    tx_payload = $urandom;
    tx_send = 1'b1;
    @(negedge clk);
    tx_send = 1'b0;
    for (int c = 0; c < 200 && txq.size() < 2; c++) @(negedge clk);
    chk("mid_reach_b2", txq.size() >= 2, 1);
    tx_send = 1'b1;
    reset = 1'b0;
    #1;
    chk("mrst_busy", tx_busy, 0);
    chk("mrst_start", uart_start_tx, 0);
    chk("mrst_txdata", uart_tx_data, 0);
    chk("mrst_payload", rx_payload, 0);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_err", rx_err, 0);
    exp_pay = '0;
    @(negedge clk);
    tx_send = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_hold = txq.size();
    repeat (50) @(negedge clk);
    chk("mrst_no_tx", txq.size(), n_hold);
    chk("mrst_idle_busy", tx_busy, 0);
    rx_frame($urandom, 1'b1, 1);

`ifdef UART_FRAME_TIMEOUT_EN
    begin
      int e0;
      e0 = n_rxerr;
      send_rx(8'hA5, 0);
      send_rx(8'h11, 0);
      for (int c = 0; c < 150 && n_rxerr == e0; c++) @(negedge clk);
      chk("tmo_err", n_rxerr - e0, 1);
      rx_frame(32'h01010101, 1'b1, 0);
    end
`endif

    chk("valid_err_excl", n_both, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
